// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding, bus bit
// meanings and the debug snapshot struct exported by the target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } i2c_tgt_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef struct packed {
    i2c_tgt_state_t state;
    logic           scl;
    logic           sda;
    logic [3:0]     bit_cnt;
  } i2c_tgt_dbg_t;

endpackage

// File: rtl/i2c_target_if.sv
// I2C pin bundle: pin levels seen by the target and its open-drain SDA pull.
interface i2c_target_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus a history flop, giving SCL edges and
// START/STOP conditions in the clk domain.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  // Reset to 1 so an idle (pulled-up) bus produces no edge when reset drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl       = scl_s2_q;
  assign sda       = sda_s2_q;
  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
endmodule

// File: rtl/i2c_target.sv
// I2C register-file responder: pointer write, auto-incrementing multi-byte
// write and read via repeated START, open-drain SDA, no clock stretching.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h6B,
  parameter int         NUM_REGS = 8,
  parameter int         IDX_W    = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst,
  i2c_target_if.slave        bus,
  output logic               busy,
  // wr_strobe is a one-clk valid with no ready: wr_idx/wr_data are meaningful
  // only while it is high, and the register file commits that byte at the end
  // of the same clk.
  output logic               wr_strobe,
  output logic [IDX_W-1:0]   wr_idx,
  output logic [7:0]         wr_data,
  input  logic               ld_en,
  input  logic [IDX_W-1:0]   ld_idx,
  input  logic [7:0]         ld_data,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [7:0]         rd_data,
  output i2c_tgt_dbg_t       dbg_o
);
  logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (bus.scl_i),
    .sda_i     (bus.sda_i),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_t   state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             rw_q, rw_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       rd_data_q;
  logic [7:0]       regs_q [NUM_REGS];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    wr_strobe_d = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR, REG, WDATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda};
            cnt_d   = cnt_q + 4'd1;
            if (state_q == WDATA && cnt_q == 4'd7) begin
              wr_strobe_d = 1'b1;
              wr_idx_d    = ptr_q;
              wr_data_d   = {shift_q[6:0], sda};
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shift_q[0];
                state_d  = ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = IDLE;
              end
            end else if (state_q == REG) begin
              ptr_d    = shift_q[IDX_W-1:0];
              sda_oe_d = 1'b1;
              state_d  = REG_ACK;
            end else begin
              ptr_d    = ptr_q + IDX_W'(1);
              sda_oe_d = 1'b1;
              state_d  = WDATA_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (rw_q == RW_READ) begin
              shift_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = REG;
            end
          end
        end
        REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            state_d  = WDATA;
          end
        end
        RDATA: begin
          // shift_q holds the byte in flight; bit 7 is always the one on the bus.
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            state_d  = RDATA_ACK;
          end else if (scl_fall && cnt_q != 4'd0) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda == I2C_ACK) begin
              ptr_d = ptr_q + IDX_W'(1);
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end else if (scl_fall) begin
            cnt_d    = 4'd0;
            shift_d  = regs_q[ptr_q];
            sda_oe_d = ~regs_q[ptr_q][7];
            state_d  = RDATA;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= RW_WRITE;
      wr_strobe_q <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      wr_strobe_q <= wr_strobe_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // The I2C write is issued after the local preload so it wins on an index clash.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
      rd_data_q <= 8'h00;
    end else begin
      if (ld_en) regs_q[ld_idx] <= ld_data;
      if (wr_strobe_q) regs_q[wr_idx_q] <= wr_data_q;
      rd_data_q <= regs_q[rd_idx];
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_idx     = wr_idx_q;
  assign wr_data    = wr_data_q;
  assign rd_data    = rd_data_q;
  assign dbg_o      = '{state: state_q, scl: scl, sda: sda, bit_cnt: cnt_q};
endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C master, write scoreboard on
// wr_strobe, and direct checks of ACK slots, read bytes and register contents.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             scl_m, sda_m;
  logic             busy, wr_strobe, ld_en;
  logic [IDX_W-1:0] wr_idx, ld_idx, rd_idx;
  logic [7:0]       wr_data, ld_data, rd_data;
  i2c_tgt_dbg_t     dbg;

  int total = 0;
  int bad = 0;
  int oe_hi_cnt = 0;
  int busy_hi_cnt = 0;
  logic [IDX_W+7:0] exp_q[$];
  logic [IDX_W+7:0] mon_exp;

  always #5 clk = ~clk;

  i2c_target_if bus ();
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  i2c_target #(.DEV_ADDR(7'h6B), .NUM_REGS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .ld_en     (ld_en),
    .ld_idx    (ld_idx),
    .ld_data   (ld_data),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .dbg_o     (dbg)
  );

  // Write monitor: every wr_strobe pops one expected {idx,data}.
  always @(negedge clk) begin
    if (bus.sda_oe) oe_hi_cnt++;
    if (busy) busy_hi_cnt++;
    if (!rst && wr_strobe) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected actual idx=%0d data=%02h required=no write", wr_idx, wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({wr_idx, wr_data} !== mon_exp) begin
          bad++;
          $display("FAIL wr_event actual idx=%0d data=%02h required idx=%0d data=%02h",
                   wr_idx, wr_data, mon_exp[IDX_W+7:8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (8) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] data, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(data[i]);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    ack = bus.sda_i;
    wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] data);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      data[i] = bus.sda_i;
      wait_q();
      scl_m = 1'b0; wait_q();
    end
    send_bit(ack);
    sda_m = 1'b1;
  endtask

  task automatic read_reg(input logic [IDX_W-1:0] idx, output logic [7:0] val);
    rd_idx = idx;
    @(negedge clk); @(negedge clk);
    val = rd_data;
  endtask

  initial begin
    logic       ack;
    logic [7:0] rx;
    logic [7:0] rd_exp [4];
    int         oe_snap, busy_snap, n;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    ld_en = 1'b0; ld_idx = '0; ld_data = 8'h00; rd_idx = '0;
    repeat (4) @(negedge clk);
    check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_idx_data", 32'({wr_idx, wr_data}), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_state", 32'(dbg.state), 32'(IDLE));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: single-byte write to reg 2
    exp_q.push_back({3'd2, 8'hA5});
    i2c_start();
    send_byte(8'hD6, ack); check("t1_addr_ack", 32'(ack), 32'(I2C_ACK));
    check("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h02, ack); check("t1_reg_ack", 32'(ack), 32'(I2C_ACK));
    send_byte(8'hA5, ack); check("t1_data_ack", 32'(ack), 32'(I2C_ACK));
    i2c_stop();
    check("t1_busy_after_stop", 32'(busy), 32'd0);
    read_reg(3'd2, rx); check("t1_reg2", 32'(rx), 32'hA5);

    // 2: preload, then wrapped read from reg 6 via repeated START
    for (int k = 0; k < 8; k++) begin
      ld_en = 1'b1; ld_idx = 3'(k); ld_data = 8'(8'h10 + k);
      @(negedge clk);
    end
    ld_en = 1'b0;
    rd_exp[0] = 8'h16; rd_exp[1] = 8'h17; rd_exp[2] = 8'h10; rd_exp[3] = 8'h11;
    i2c_start();
    send_byte(8'hD6, ack); check("t2_addr_w_ack", 32'(ack), 32'(I2C_ACK));
    send_byte(8'h06, ack); check("t2_reg_ack", 32'(ack), 32'(I2C_ACK));
    i2c_rstart();
    send_byte(8'hD7, ack); check("t2_addr_r_ack", 32'(ack), 32'(I2C_ACK));
    for (int b = 0; b < 4; b++) begin
      recv_byte((b == 3) ? I2C_NACK : I2C_ACK, rx);
      check($sformatf("t2_rd_byte%0d", b), 32'(rx), 32'(rd_exp[b]));
    end
    check("t2_busy_after_nack", 32'(busy), 32'd0);
    check("t2_state_after_nack", 32'(dbg.state), 32'(IDLE));
    i2c_stop();

    // 3: address mismatch is ignored entirely
    oe_snap = oe_hi_cnt; busy_snap = busy_hi_cnt;
    i2c_start();
    send_byte(8'hA0, ack); check("t3_addr_nack", 32'(ack), 32'(I2C_NACK));
    send_byte(8'h55, ack); check("t3_data_nack", 32'(ack), 32'(I2C_NACK));
    i2c_stop();
    check("t3_oe_never", 32'(oe_hi_cnt - oe_snap), 32'd0);
    check("t3_busy_never", 32'(busy_hi_cnt - busy_snap), 32'd0);

    // 4: STOP mid-byte aborts the write; a following full write lands
    i2c_start();
    send_byte(8'hD6, ack); check("t4_addr_ack", 32'(ack), 32'(I2C_ACK));
    send_byte(8'h04, ack); check("t4_reg_ack", 32'(ack), 32'(I2C_ACK));
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    check("t4_state_idle", 32'(dbg.state), 32'(IDLE));
    read_reg(3'd4, rx); check("t4_reg4_kept", 32'(rx), 32'h14);
    exp_q.push_back({3'd4, 8'h3C});
    i2c_start();
    send_byte(8'hD6, ack);
    send_byte(8'h04, ack);
    send_byte(8'h3C, ack); check("t4_retry_ack", 32'(ack), 32'(I2C_ACK));
    i2c_stop();
    read_reg(3'd4, rx); check("t4_reg4", 32'(rx), 32'h3C);

    // 5: reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'hD6 >> i) & 8'h01) != 0);
    sda_m = 1'b1;
    n = 0;
    while (!bus.sda_oe && n < 100) begin @(negedge clk); n++; end
    check("t5_ack_driven", 32'(bus.sda_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_oe_after_rst", 32'(bus.sda_oe), 32'd0);
    check("t5_state_after_rst", 32'(dbg.state), 32'(IDLE));
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      read_reg(3'(k), rx); check($sformatf("t5_reg%0d_zero", k), 32'(rx), 32'd0);
    end

    // 6: local preload and I2C write to the same index in the same clk
    exp_q.push_back({3'd3, 8'hAA});
    i2c_start();
    send_byte(8'hD6, ack);
    send_byte(8'h03, ack); check("t6_reg_ack", 32'(ack), 32'(I2C_ACK));
    fork
      send_byte(8'hAA, ack);
      begin
        n = 0;
        while (!wr_strobe && n < 2000) begin @(negedge clk); n++; end
        check("t6_strobe_seen", 32'(n < 2000), 32'd1);
        ld_en = 1'b1; ld_idx = 3'd3; ld_data = 8'h55;
        @(negedge clk);
        ld_en = 1'b0;
      end
    join
    i2c_stop();
    read_reg(3'd3, rx); check("t6_reg3_i2c_wins", 32'(rx), 32'hAA);

    repeat (4) @(negedge clk);
    check("writes_all_seen", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
